// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage bundle between the decoder/ID-EX register and the hazard controller.
// The master drives the decoded ID fields; the slave returns selects, gated controls and stall.
interface pipe_hazard_ctrl_if;
    logic [4:0]  IDrs;
    logic [4:0]  IDrt;
    logic        IDuseRs;
    logic        IDuseRt;
    logic        IDshift;
    logic        IDaluImm;
    logic        IDwreg;
    logic        IDm2reg;
    logic        IDwmem;
    logic [4:0]  IDwn;
    logic [1:0]  selectAlua;
    logic [1:0]  selectAlub;
    logic        isStoreHazards;
    logic        wregOut;
    logic        m2regOut;
    logic        wmemOut;
    logic        stall;
    logic [15:0] stallCount;

    modport master (
        output IDrs, IDrt, IDuseRs, IDuseRt, IDshift, IDaluImm,
               IDwreg, IDm2reg, IDwmem, IDwn,
        input  selectAlua, selectAlub, isStoreHazards,
               wregOut, m2regOut, wmemOut, stall, stallCount
    );

    modport slave (
        input  IDrs, IDrt, IDuseRs, IDuseRt, IDshift, IDaluImm,
               IDwreg, IDm2reg, IDwmem, IDwn,
        output selectAlua, selectAlub, isStoreHazards,
               wregOut, m2regOut, wmemOut, stall, stallCount
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Forwarding / hazard controller for the ID stage: shadows the EX and MEM destinations,
// picks ALU operand sources, flags store-data hazards and stalls on load-use / distance-2 stores.
module pipe_hazard_ctrl (
    input logic              clk,
    input logic              clrn,
    pipe_hazard_ctrl_if.slave id
);
    typedef struct packed {
        logic [4:0] wn;
        logic       wreg;
        logic       m2reg;
    } shadow_t;

    shadow_t     ex_q;
    shadow_t     mem_q;
    logic [15:0] stall_cnt_q;

    logic rs_e, rs_m, rt_e, rt_m;
    logic load_use, store_d2, stall_c;

    function automatic logic hit(input shadow_t s, input logic [4:0] r);
        return s.wreg && (s.wn == r) && (r != '0);
    endfunction

    // Matches are masked by clrn so nothing but the static selects leaks out during reset.
    always_comb begin
        rs_e     = clrn & hit(ex_q, id.IDrs);
        rs_m     = clrn & hit(mem_q, id.IDrs);
        rt_e     = clrn & hit(ex_q, id.IDrt);
        rt_m     = clrn & hit(mem_q, id.IDrt);
        load_use = ex_q.m2reg & ((id.IDuseRs & ~id.IDshift & rs_e) |
                                 (id.IDuseRt & ~id.IDaluImm & rt_e));
        store_d2 = id.IDwmem & id.IDuseRt & rt_m & ~rt_e;
        stall_c  = clrn & (load_use | store_d2);
    end

    always_comb begin
        id.selectAlua = 2'd0;
        if (id.IDshift)                 id.selectAlua = 2'd1;
        else if (id.IDuseRs && rs_e)    id.selectAlua = 2'd2;
        else if (id.IDuseRs && rs_m)    id.selectAlua = 2'd3;

        id.selectAlub = 2'd0;
        if (id.IDaluImm)                id.selectAlub = 2'd1;
        else if (id.IDuseRt && rt_e)    id.selectAlub = 2'd2;
        else if (id.IDuseRt && rt_m)    id.selectAlub = 2'd3;

        id.stall          = stall_c;
        id.isStoreHazards = clrn & id.IDwmem & id.IDuseRt & rt_e & ~stall_c;
        id.wregOut        = clrn & id.IDwreg  & ~stall_c;
        id.m2regOut       = clrn & id.IDm2reg & ~stall_c;
        id.wmemOut        = clrn & id.IDwmem  & ~stall_c;
        id.stallCount     = stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            ex_q        <= '0;
            mem_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            mem_q       <= ex_q;
            ex_q        <= '{wn: id.IDwn, wreg: id.wregOut, m2reg: id.m2regOut};
            if (stall_c && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed selects, stalls and counter values.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic clrn;
    int   total;
    int   passed;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl dut (
        .clk  (clk),
        .clrn (clrn),
        .id   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic sh, input logic imm,
                         input logic wr, input logic m2, input logic wm, input logic [4:0] wn);
        bus.IDrs     = rs;
        bus.IDrt     = rt;
        bus.IDuseRs  = urs;
        bus.IDuseRt  = urt;
        bus.IDshift  = sh;
        bus.IDaluImm = imm;
        bus.IDwreg   = wr;
        bus.IDm2reg  = m2;
        bus.IDwmem   = wm;
        bus.IDwn     = wn;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        clrn   = 1'b0;

        // Reset: a shifting load-like instruction sees only the static selects
        drive(5'd3, 5'd3, 1, 1, 1, 0, 1, 1, 1, 5'd3);
        chk("rst_sela", bus.selectAlua, 2'd1);
        chk("rst_selb", bus.selectAlub, 2'd0);
        chk("rst_stall", bus.stall, 1'b0);
        chk("rst_wreg", bus.wregOut, 1'b0);
        chk("rst_m2reg", bus.m2regOut, 1'b0);
        chk("rst_wmem", bus.wmemOut, 1'b0);
        chk("rst_store", bus.isStoreHazards, 1'b0);
        step();
        chk("rst_count", bus.stallCount, 16'd0);
        clrn = 1'b1;

        // Distance-1 forward: add $3,$1,$2 ; sub $4,$3,$5
        drive(5'd1, 5'd2, 1, 1, 0, 0, 1, 0, 0, 5'd3);
        chk("add_wreg", bus.wregOut, 1'b1);
        chk("add_sela", bus.selectAlua, 2'd0);
        step();
        drive(5'd3, 5'd5, 1, 1, 0, 0, 1, 0, 0, 5'd4);
        chk("d1_sela", bus.selectAlua, 2'd2);
        chk("d1_selb", bus.selectAlub, 2'd0);
        chk("d1_stall", bus.stall, 1'b0);
        step();

        // Distance-2 forward: add $3 ; and $7,$8,$9 ; or $6,$5,$3
        drive(5'd1, 5'd2, 1, 1, 0, 0, 1, 0, 0, 5'd3);
        step();
        drive(5'd8, 5'd9, 1, 1, 0, 0, 1, 0, 0, 5'd7);
        step();
        drive(5'd5, 5'd3, 1, 1, 0, 0, 1, 0, 0, 5'd6);
        chk("d2_selb", bus.selectAlub, 2'd3);
        chk("d2_sela", bus.selectAlua, 2'd0);
        chk("d2_stall", bus.stall, 1'b0);
        step();

        // Newest producer wins: add $3 ; addi $3,$3,imm ; sub $4,$3,$3
        drive(5'd1, 5'd2, 1, 1, 0, 0, 1, 0, 0, 5'd3);
        step();
        drive(5'd3, 5'd0, 1, 0, 0, 1, 1, 0, 0, 5'd3);
        chk("addi_sela", bus.selectAlua, 2'd2);
        chk("addi_selb", bus.selectAlub, 2'd1);
        step();
        drive(5'd3, 5'd3, 1, 1, 0, 0, 1, 0, 0, 5'd4);
        chk("prio_sela", bus.selectAlua, 2'd2);
        chk("prio_selb", bus.selectAlub, 2'd2);
        step();

        // Load-use: lw $3,0($1) ; add $4,$3,$1
        drive(5'd1, 5'd0, 1, 0, 0, 1, 1, 1, 0, 5'd3);
        chk("lw_stall", bus.stall, 1'b0);
        chk("lw_m2reg", bus.m2regOut, 1'b1);
        step();
        drive(5'd3, 5'd1, 1, 1, 0, 0, 1, 0, 0, 5'd4);
        chk("lu_stall", bus.stall, 1'b1);
        chk("lu_wreg", bus.wregOut, 1'b0);
        chk("lu_count0", bus.stallCount, 16'd0);
        step();
        chk("lu_count1", bus.stallCount, 16'd1);
        chk("lu2_stall", bus.stall, 1'b0);
        chk("lu2_sela", bus.selectAlua, 2'd3);
        chk("lu2_wreg", bus.wregOut, 1'b1);
        step();

        // Load then dependent store: no stall, store data fixed in MEM
        drive(5'd1, 5'd0, 1, 0, 0, 1, 1, 1, 0, 5'd3);
        step();
        drive(5'd1, 5'd3, 1, 1, 0, 1, 0, 0, 1, 5'd0);
        chk("lsw_store", bus.isStoreHazards, 1'b1);
        chk("lsw_stall", bus.stall, 1'b0);
        chk("lsw_selb", bus.selectAlub, 2'd1);
        chk("lsw_wmem", bus.wmemOut, 1'b1);
        step();

        // Distance-2 store: add $3 ; nop ; sw $3,0($1)
        drive(5'd1, 5'd2, 1, 1, 0, 0, 1, 0, 0, 5'd3);
        step();
        drive(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0);
        step();
        drive(5'd1, 5'd3, 1, 1, 0, 1, 0, 0, 1, 5'd0);
        chk("sd2_stall", bus.stall, 1'b1);
        chk("sd2_store", bus.isStoreHazards, 1'b0);
        chk("sd2_wmem", bus.wmemOut, 1'b0);
        step();
        chk("sd2b_stall", bus.stall, 1'b0);
        chk("sd2b_wmem", bus.wmemOut, 1'b1);
        chk("sd2b_count", bus.stallCount, 16'd2);
        step();

        // $0 is never forwarded
        drive(5'd1, 5'd2, 1, 1, 0, 0, 1, 0, 0, 5'd0);
        step();
        drive(5'd0, 5'd0, 1, 1, 0, 0, 1, 0, 0, 5'd5);
        chk("r0_sela", bus.selectAlua, 2'd0);
        chk("r0_selb", bus.selectAlub, 2'd0);
        chk("r0_stall", bus.stall, 1'b0);
        step();

        // Reset in the middle of a load-use stall
        drive(5'd1, 5'd0, 1, 0, 0, 1, 1, 1, 0, 5'd3);
        step();
        drive(5'd3, 5'd1, 1, 1, 0, 0, 1, 0, 0, 5'd4);
        chk("mr_stall", bus.stall, 1'b1);
        clrn = 1'b0;
        #1;
        chk("mr_stall_drop", bus.stall, 1'b0);
        chk("mr_wreg", bus.wregOut, 1'b0);
        step();
        chk("mr_count", bus.stallCount, 16'd0);
        clrn = 1'b1;
        #1;
        chk("mr_after_stall", bus.stall, 1'b0);
        chk("mr_after_sela", bus.selectAlua, 2'd0);
        chk("mr_after_wreg", bus.wregOut, 1'b1);
        step();
        chk("mr_after_count", bus.stallCount, 16'd0);

        // Saturation: counter preloaded just below the ceiling
        drive(5'd1, 5'd0, 1, 0, 0, 1, 1, 1, 0, 5'd3);
        step();
        drive(5'd3, 5'd1, 1, 1, 0, 0, 1, 0, 0, 5'd4);
        chk("sat_stall", bus.stall, 1'b1);
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        #1;
        chk("sat_preload", bus.stallCount, 16'hFFFE);
        step();
        chk("sat_reach", bus.stallCount, 16'hFFFF);
        drive(5'd1, 5'd3, 1, 1, 0, 1, 0, 0, 1, 5'd0);
        chk("sat_stall2", bus.stall, 1'b1);
        step();
        chk("sat_hold1", bus.stallCount, 16'hFFFF);
        drive(5'd1, 5'd0, 1, 0, 0, 1, 1, 1, 0, 5'd3);
        step();
        drive(5'd3, 5'd1, 1, 1, 0, 0, 1, 0, 0, 5'd4);
        chk("sat_stall3", bus.stall, 1'b1);
        step();
        chk("sat_hold2", bus.stallCount, 16'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Forwarding and hazard controller for the five-stage pipeline. It sits in the ID stage and produces the ALU-operand select codes, the store-data hazard flag and the write enables that the ID/EX register carries into EX. It keeps its own shadow copy of the destinations of the two instructions ahead of ID, and stalls IF/ID for one cycle on load-use and distance-2 store-data hazards. It also keeps a saturating stall counter for performance measurement.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on rising edge
- clrn  in  1  synchronous active-low reset, sampled on rising edge of clk
- IDrs  in  5  rs field of the instruction in ID
- IDrt  in  5  rt field of the instruction in ID
- IDuseRs  in  1  instruction reads rs as ALU operand a
- IDuseRt  in  1  instruction reads rt (ALU operand b, or store data)
- IDshift  in  1  operand a is the shift amount (select 1)
- IDaluImm  in  1  operand b is the immediate (select 1)
- IDwreg, IDm2reg, IDwmem  in  1 each  decoded control of the ID instruction
- IDwn  in  5  decoded destination register
- selectAlua, selectAlub  out  2 each  0=qa/qb, 1=saOrImme, 2=MEMaluResult, 3=WBdata
- isStoreHazards  out  1  store data must be replaced by WB-stage data in MEM
- wregOut, m2regOut, wmemOut  out  1 each  gated controls to the ID/EX register
- stall  out  1  hold PC and IF/ID; ID/EX receives a bubble
- stallCount  out  16  saturating count of stall cycles

## Operation
- Shadow state holds two entries: E (the instruction now in EX) and M (the instruction now in MEM). Each entry has wn[4:0], wreg and m2reg.
- On each clock edge with clrn=1: M<=E. E<={IDwn, wregOut, m2regOut}. If stall=1, the E entry becomes a bubble because the gated outputs are 0.
- Matching rules:
  - matchE(r) = E.wreg & (E.wn==r) & (r!=0)
  - matchM(r) = M.wreg & (M.wn==r) & (r!=0)
- Operand a:
  - If IDshift: select 1.
  - Else if IDuseRs & matchE(rs): select 2.
  - Else if IDuseRs & matchM(rs): select 3.
  - Else: select 0.
- Operand b:
  - If IDaluImm: select 1.
  - Else if IDuseRt & matchE(rt): select 2.
  - Else if IDuseRt & matchM(rt): select 3.
  - Else: select 0.
  - E takes priority over M, so the newest producer wins.
- The register file is write-before-read, so an instruction three ahead needs no forwarding.
- Stall conditions (any one sets stall=1):
  - Load-use: E.m2reg & ((IDuseRs & !IDshift & matchE(rs)) | (IDuseRt & !IDaluImm & matchE(rt))).
  - Store distance-2: IDwmem & IDuseRt & matchM(rt) & !matchE(rt).
- isStoreHazards = IDwmem & IDuseRt & matchE(rt) & !stall. This covers both a load and an ALU producer at distance 1; no stall is needed for a load followed by a dependent store.
- Gated outputs: wregOut=IDwreg&!stall, m2regOut=IDm2reg&!stall, wmemOut=IDwmem&!stall.
- The select codes are don't-care when stall=1. The EX side ignores them because the bubble has no side effects.
- stallCount increments on each edge where stall=1 and clrn=1. It saturates at 16'hFFFF and does not wrap.

## Timing
- Select and stall outputs are combinational from the ID inputs and the shadow state, valid within the same cycle. The ID/EX register captures them at the next edge.
- A load-use stall lasts exactly one cycle. In the next cycle the load is in M, so the consumer gets select 3 and stall=0.
- A distance-2 store stall lasts one cycle. The producer then reaches WB, and the write-before-read register file resolves the data.
- Reset: an edge with clrn=0 clears E, M and stallCount to 0.
- While clrn=0, stall=0, isStoreHazards=0, wregOut=m2regOut=wmemOut=0, and the selects reflect only IDshift/IDaluImm (1) or 0.
- Reset mid-stall drops the stall immediately. The stalled instruction re-enters cleanly after reset.
- Back-to-back loads to the same register: only the newest (E) producer is considered.

## Test plan
- Forward distance 1:
  - Stimulus: add $3,$1,$2 issued, then sub $4,$3,$5 in ID.
  - Required: selectAlua=2, selectAlub=0, stall=0.
- Forward distance 2:
  - Stimulus: add $3 issued, then an unrelated instruction, then or $6,$5,$3.
  - Required: selectAlub=3, selectAlua=0.
- Load-use:
  - Stimulus: lw $3 issued, then add $4,$3,$1.
  - Required: stall=1 for one cycle, wregOut=0, stallCount goes 0->1. Next cycle selectAlua=3, stall=0.
- Store data:
  - Stimulus: lw $3 issued, then sw $3,0($1).
  - Required: isStoreHazards=1, stall=0, selectAlub=1.
  - Stimulus: add $3 issued, nop, then sw $3.
  - Required: stall=1 for one cycle.
- $0 and reset:
  - Stimulus: a writer to $0 followed by a reader of $0.
  - Required: selects=0, no stall.
  - Stimulus: clrn=0 asserted during a load-use stall.
  - Required: stall=0 immediately; E, M and stallCount cleared after the edge.
- Saturation:
  - Stimulus: preload via 65535 stalls, then one more stall.
  - Required: stallCount=16'hFFFF and holds.
